hazard_ctrl: RTL and testbench

- Central pipeline scheduler for the 5-stage RISC-V core.
- Drives the enable, bubble and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC enable.
- Detects load-use hazards and computes registered operand-forwarding selects for the instruction entering EX.
- Freezes the pipeline while a multi-cycle EX operation is busy, and squashes wrong-path instructions on a taken branch.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/mc_busy_cnt.sv | 39 +++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-mux encodings, the x0 address and the shadow-slot types
// the hazard controller uses to track what sits in EX and MEM.
package pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic       mc;
    } ex_slot_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
    } mem_slot_t;

    // Picks the operand source for a register read. The EX producer is younger than the MEM one
    // and wins. A load in EX has no data yet; the load-use stall covers that case instead.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input ex_slot_t ex,
                                           input mem_slot_t mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex.wr && ex.rd != REG_X0 && rs == ex.rd && !ex.load) begin
            sel = FWD_EXMEM;
        end else if (mem.wr && mem.rd != REG_X0 && rs == mem.rd) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mc_busy_cnt.sv
// Loadable down-counter that tracks how long a multi-cycle op still has to spend in EX.
// CNT_W must be wide enough to hold MC_LAT-1.
module mc_busy_cnt #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LoadVal = CNT_W'(MC_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    // High in the last frozen cycle; the op leaves EX on the following cycle.
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage core: load-use stall, multi-cycle freeze, branch squash and
// registered operand-forwarding selects for the instruction about to enter EX.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1_ad,
    input  logic [4:0] id_rs2_ad,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd_ad,
    input  logic       id_rdEn,
    input  logic       id_is_load,
    input  logic       id_is_mc,
    input  logic       ex_branch_taken,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_bubble,
    output logic       ex_mem_en,
    output logic [1:0] fwd1_sel,
    output logic [1:0] fwd2_sel
);

    ex_slot_t   ex_q, ex_d;
    mem_slot_t  mem_q, mem_d;
    logic [1:0] fwd1_q, fwd1_d;
    logic [1:0] fwd2_q, fwd2_d;

    ex_slot_t id_slot;
    logic     lu;
    logic     freeze;
    logic     branch;
    logic     mc_start;
    logic     mc_busy;
    logic     mc_done;
    logic     unused_mc_done;

    assign id_slot = '{
        rd:   id_rd_ad,
        wr:   id_valid & id_rdEn,
        load: id_valid & id_is_load,
        mc:   id_valid & id_is_mc
    };

    assign lu = id_valid && ex_q.wr && ex_q.load && (ex_q.rd != REG_X0) &&
                ((id_rs1_used && id_rs1_ad == ex_q.rd) || (id_rs2_used && id_rs2_ad == ex_q.rd));

    assign freeze = ex_q.mc & mc_busy;
    assign branch = ex_branch_taken & ~freeze;

    // Counter is loaded as the mc op enters EX so the freeze covers MC_LAT-1 cycles and the op
    // advances on the cycle the count returns to zero.
    assign mc_start = id_ex_en & ~id_ex_bubble & id_slot.mc;

    mc_busy_cnt #(
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) u_mc_busy_cnt (
        .clk     (clk),
        .rst     (rst),
        .start_i (mc_start),
        .busy_o  (mc_busy),
        .done_o  (mc_done)
    );

    assign unused_mc_done = mc_done;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b1;
        if (!rst) begin
            if (freeze) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end else if (branch) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d   = ex_q;
        mem_d  = mem_q;
        fwd1_d = fwd1_q;
        fwd2_d = fwd2_q;
        if (id_ex_en) begin
            if (id_ex_bubble) begin
                ex_d   = '0;
                fwd1_d = FWD_RF;
                fwd2_d = FWD_RF;
            end else begin
                ex_d   = id_slot;
                fwd1_d = fwd_sel(id_rs1_ad, ex_q, mem_q);
                fwd2_d = fwd_sel(id_rs2_ad, ex_q, mem_q);
            end
        end
        if (ex_mem_en) begin
            mem_d = '{rd: ex_q.rd, wr: ex_q.wr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= '0;
            mem_q  <= '0;
            fwd1_q <= FWD_RF;
            fwd2_q <= FWD_RF;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= mem_d;
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
        end
    end

    assign fwd1_sel = fwd1_q;
    assign fwd2_sel = fwd2_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: each step drives one ID instruction and queues the control
// word expected in that cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_ad, id_rs2_ad, id_rd_ad;
    logic       id_rs1_used, id_rs2_used, id_rdEn, id_is_load, id_is_mc;
    logic       ex_branch_taken;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
    logic [1:0] fwd1_sel, fwd2_sel;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MC_LAT (4),
        .CNT_W  (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1_ad       (id_rs1_ad),
        .id_rs2_ad       (id_rs2_ad),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd_ad        (id_rd_ad),
        .id_rdEn         (id_rdEn),
        .id_is_load      (id_is_load),
        .id_is_mc        (id_is_mc),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_en       (ex_mem_en),
        .fwd1_sel        (fwd1_sel),
        .fwd2_sel        (fwd2_sel)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mc;
    } ins_t;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;

    // Control word order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en.
    localparam logic [5:0] C_NORM  = 6'b110101;
    localparam logic [5:0] C_STALL = 6'b000111;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_FLUSH = 6'b111111;
    localparam ins_t       IDLE    = '0;

    int  n_checks = 0;
    int  n_fails  = 0;
    sb_t sb_q[$];

    logic [9:0] obs;
    assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
                  fwd1_sel, fwd2_sel};

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
        ins_t i;
        i     = '0;
        i.v   = 1'b1;
        i.rs1 = rs1;
        i.rs2 = rs2;
        i.u1  = 1'b1;
        i.u2  = 1'b1;
        i.rd  = rd;
        i.wr  = 1'b1;
        return i;
    endfunction

    function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        ins_t i;
        i    = alu(rd, rs1, 5'd0);
        i.u2 = 1'b0;
        i.ld = 1'b1;
        return i;
    endfunction

    function automatic ins_t mul(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
        ins_t i;
        i    = alu(rd, rs1, rs2);
        i.mc = 1'b1;
        return i;
    endfunction

    task automatic drive(input logic r, input ins_t ins, input logic br);
        rst             = r;
        id_valid        = ins.v;
        id_rs1_ad       = ins.rs1;
        id_rs2_ad       = ins.rs2;
        id_rs1_used     = ins.u1;
        id_rs2_used     = ins.u2;
        id_rd_ad        = ins.rd;
        id_rdEn         = ins.wr;
        id_is_load      = ins.ld;
        id_is_mc        = ins.mc;
        ex_branch_taken = br;
    endtask

    task automatic step(input string tag, input logic r, input ins_t ins, input logic br,
                        input logic [5:0] ctl, input logic [1:0] f1, input logic [1:0] f2);
        sb_t e;
        drive(r, ins, br);
        e.tag = tag;
        e.exp = {ctl, f1, f2};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.exp);
        end
    end

    initial begin
        drive(1'b1, IDLE, 1'b0);
        @(posedge clk);
        #1;
        step("reset",        1'b1, IDLE,           1'b0, C_NORM,  2'b00, 2'b00);
        // Load-use on rs1, then MEM/WB forwarding once the consumer reaches EX
        step("lu_load_id",   1'b0, ld(5, 1),       1'b0, C_NORM,  2'b00, 2'b00);
        step("lu_stall",     1'b0, alu(6, 5, 2),   1'b0, C_STALL, 2'b00, 2'b00);
        step("lu_release",   1'b0, alu(6, 5, 2),   1'b0, C_NORM,  2'b00, 2'b00);
        step("lu_fwd_memwb", 1'b0, IDLE,           1'b0, C_NORM,  2'b10, 2'b00);
        // EX/MEM forwarding on rs2, and the same shape through x0
        step("ex_prod",      1'b0, alu(3, 1, 2),   1'b0, C_NORM,  2'b00, 2'b00);
        step("ex_cons",      1'b0, alu(4, 1, 3),   1'b0, C_NORM,  2'b00, 2'b00);
        step("ex_fwd_exmem", 1'b0, alu(0, 1, 2),   1'b0, C_NORM,  2'b00, 2'b01);
        step("x0_cons",      1'b0, alu(4, 1, 0),   1'b0, C_NORM,  2'b00, 2'b00);
        step("x0_no_fwd",    1'b0, alu(7, 1, 2),   1'b0, C_NORM,  2'b00, 2'b00);
        // x7 written by both EX and MEM producers
        step("young_p2",     1'b0, alu(7, 1, 2),   1'b0, C_NORM,  2'b00, 2'b00);
        step("young_cons",   1'b0, alu(8, 7, 7),   1'b0, C_NORM,  2'b00, 2'b00);
        step("young_wins",   1'b0, IDLE,           1'b0, C_NORM,  2'b01, 2'b01);
        // Multi-cycle op: three frozen cycles, branch ignored until the count expires
        step("mc_issue",     1'b0, mul(9, 1, 2),   1'b0, C_NORM,  2'b00, 2'b00);
        step("mc_busy_a",    1'b0, alu(10, 9, 2),  1'b0, C_FRZ,   2'b00, 2'b00);
        step("mc_busy_br",   1'b0, alu(10, 9, 2),  1'b1, C_FRZ,   2'b00, 2'b00);
        step("mc_busy_c",    1'b0, alu(10, 9, 2),  1'b0, C_FRZ,   2'b00, 2'b00);
        step("mc_end_br",    1'b0, alu(10, 9, 2),  1'b1, C_FLUSH, 2'b00, 2'b00);
        step("br_bubble",    1'b0, IDLE,           1'b0, C_NORM,  2'b00, 2'b00);
        // Branch coincident with load-use: flush wins
        step("lu2_load_id",  1'b0, ld(5, 1),       1'b0, C_NORM,  2'b00, 2'b00);
        step("br_over_lu",   1'b0, alu(6, 5, 2),   1'b1, C_FLUSH, 2'b00, 2'b00);
        // Reset during a busy count with a non-zero forward select pending
        step("mc2_issue",    1'b0, mul(9, 5, 2),   1'b0, C_NORM,  2'b00, 2'b00);
        step("mc2_busy",     1'b0, alu(12, 9, 2),  1'b0, C_FRZ,   2'b10, 2'b00);
        step("rst_in_busy",  1'b1, alu(12, 9, 2),  1'b0, C_NORM,  2'b10, 2'b00);
        step("post_rst_a",   1'b0, alu(12, 9, 2),  1'b0, C_NORM,  2'b00, 2'b00);
        step("post_rst_b",   1'b0, IDLE,           1'b0, C_NORM,  2'b00, 2'b00);
        step("post_rst_c",   1'b0, IDLE,           1'b0, C_NORM,  2'b00, 2'b00);
        @(negedge clk);
        #1;
        check_eq("sb_drained", 10'(sb_q.size()), 10'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
